// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared mode encodings for the LED pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        c_MODE_UP     = 2'd0,
        c_MODE_DOWN   = 2'd1,
        c_MODE_BOUNCE = 2'd2,
        c_MODE_HOLD   = 2'd3
    } led_mode_e;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler; wrap is high on the last count of
//               each period while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic clk100,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int              c_CW   = $clog2(TICK_CYCLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_CYCLES - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk100) begin
        if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

    assign wrap = en & (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : LED pattern generator (count up/down, one-hot bounce, hold)
//               advanced by a prescaler wrap or a manual step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int TICK_CYCLES = 100000000,
    parameter int WIDTH       = 8
) (
    input  logic             clk100,
    input  logic             clr,
    input  logic             en,
    input  logic             step,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led_vals,
    output logic             tick
);

    led_mode_e        w_mode;
    logic             w_wrap;
    logic             w_mode_chg;
    logic             w_adv;

    led_mode_e        r_mode_q;
    logic             r_dir;
    logic [WIDTH-1:0] r_led;
    logic             r_tick;

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk100 (clk100),
        .clr    (clr),
        .en     (en),
        .wrap   (w_wrap)
    );

    assign w_mode     = led_mode_e'(mode);
    assign w_mode_chg = (w_mode != r_mode_q);
    assign w_adv      = w_wrap | step;

    // A mode-change edge takes priority and swallows any coincident advance.
    always_ff @(posedge clk100) begin
        if (clr) begin
            r_led    <= '0;
            r_dir    <= 1'b0;
            r_mode_q <= c_MODE_UP;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_mode_chg) begin
                r_mode_q <= w_mode;
                if (w_mode == c_MODE_BOUNCE) begin
                    r_led <= WIDTH'(1);
                    r_dir <= 1'b0;
                end
            end else if (w_adv) begin
                case (r_mode_q)
                    c_MODE_UP:   r_led <= r_led + WIDTH'(1);
                    c_MODE_DOWN: r_led <= r_led - WIDTH'(1);
                    c_MODE_BOUNCE: begin
                        if (!r_dir) begin
                            if (r_led[WIDTH-1]) begin
                                r_dir <= 1'b1;
                                r_led <= r_led >> 1;
                            end else begin
                                r_led <= r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                r_dir <= 1'b0;
                                r_led <= r_led << 1;
                            end else begin
                                r_led <= r_led >> 1;
                            end
                        end
                    end
                    default: r_led <= r_led;
                endcase
            end
        end
    end

    assign led_vals = r_led;
    assign tick     = r_tick;

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001: Parameter TICK_CYCLES, default 100000000, clock cycles per pattern advance; SHALL be >= 2.
REQ-002: Parameter WIDTH, default 8, LED vector width; SHALL be >= 2.
REQ-003: clk100  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004: clr  input  1  reset, synchronous, active-high.
REQ-005: en  input  1  prescaler run enable; 1 = counting, 0 = prescaler holds its value.
REQ-006: step  input  1  manual advance request, one-cycle pulse.
REQ-007: mode  input  2  pattern select: 0 = UP, 1 = DOWN, 2 = BOUNCE, 3 = HOLD.
REQ-008: led_vals  output  WIDTH  registered LED pattern.
REQ-009: tick  output  1  registered one-cycle pulse marking each prescaler wrap.

Function
REQ-010: Prescaler width SHALL be $clog2(TICK_CYCLES); count 0..TICK_CYCLES-1 while en=1, then wrap to 0.
REQ-011: Wrap event = en=1 and prescaler == TICK_CYCLES-1; with en held at 1, a wrap SHALL occur every TICK_CYCLES cycles exactly.
REQ-012: tick SHALL be 1 for exactly the one cycle after each wrap edge, otherwise 0, in every mode.
REQ-013: Advance event = wrap event OR step=1; a simultaneous wrap and step SHALL produce one advance only.
REQ-014: step SHALL NOT alter the prescaler count.
REQ-015: On an advance edge, led_vals SHALL update so the new value is visible the next cycle (latency 1).
REQ-016: UP: led_vals <= led_vals+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-017: DOWN: led_vals <= led_vals-1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-018: BOUNCE: one-hot shift with internal direction bit dir (0 = toward MSB).
REQ-019: BOUNCE, dir=0: if led_vals[WIDTH-1]=1, set dir=1 and shift right by 1; else shift left by 1.
REQ-020: BOUNCE, dir=1: if led_vals[0]=1, set dir=0 and shift left by 1; else shift right by 1.
REQ-021: BOUNCE sequence for WIDTH=4 SHALL be 1,2,4,8,4,2,1,2,... with period 2*(WIDTH-1) advances.
REQ-022: HOLD: led_vals SHALL NOT change; step SHALL be ignored.
REQ-023: A registered copy mode_q SHALL track mode; mode != mode_q marks a mode change, and mode_q <= mode on that edge.
REQ-024: Mode change into BOUNCE: led_vals <= 1 and dir <= 0 on that edge.
REQ-025: Mode change into UP, DOWN or HOLD: led_vals SHALL retain its value.
REQ-026: Any advance coinciding with a mode-change edge SHALL be dropped.
REQ-027: Prescaler and tick SHALL be unaffected by mode changes.

Reset
REQ-028: clr=1 at a rising edge SHALL set prescaler=0, led_vals=0, tick=0, dir=0, mode_q=UP.
REQ-029: clr SHALL override en, step and mode; a mid-period clr SHALL discard the partial count, so the first wrap falls TICK_CYCLES cycles after release.
REQ-030: If mode=BOUNCE when clr releases, REQ-024 SHALL apply on the first edge after release, giving led_vals=1.

Structure
REQ-031: Mode encodings (UP, DOWN, BOUNCE, HOLD) SHALL be defined as named constants in the shared package led_pkg; no literal mode values in RTL.
REQ-032: The prescaler SHALL be a sub-module tick_gen (parameter TICK_CYCLES; ports clk100, clr, en, wrap), reusable elsewhere.
REQ-033: Pattern update logic SHALL be a single clocked process in led_pattern_gen.

Verification (TICK_CYCLES=4, WIDTH=4 unless stated)
REQ-034: clr 3 cycles, then mode=UP, en=1 for 80 cycles -> led_vals 0,1,..,15,0,1,2,3,4, each change exactly 4 cycles apart; tick high one cycle per change.
REQ-035: mode=DOWN from led_vals=0, en=1 -> 15,14,13 after the 1st, 2nd and 3rd wraps.
REQ-036: mode switched to BOUNCE -> led_vals=1 on the next cycle, then 2,4,8,4,2,1,2 on successive wraps.
REQ-037: en=0 with step pulses, including one coinciding with a wrap under en=1 -> exactly one advance per step, one advance at the coincident cycle, prescaler value unchanged by step.
REQ-038: clr asserted with prescaler=2 and led_vals=5 -> all outputs 0 next cycle; first tick exactly 4 cycles after release.
REQ-039: mode=HOLD with en=1 and step pulses -> led_vals constant, tick still pulsing every 4 cycles.
